// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB fetch predictor with EX-stage training and registered redirect.
// Optional BP_STATS_EN adds branch and mispredict event counters.
module branch_predictor #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef BP_STATS_EN
    ,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
`endif
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic [ENTRIES-1:0]  valid_q;
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0]   if_tag, ex_tag;
    logic                  ex_hit, upd, mis_d;
    logic [1:0]            ctr_nxt;
    logic                  unused_pc_bits;

    assign if_idx = if_pc[INDEX_BITS+1:2];
    assign if_tag = if_pc[TAG_HI:TAG_LO];
    assign ex_idx = ex_pc[INDEX_BITS+1:2];
    assign ex_tag = ex_pc[TAG_HI:TAG_LO];
    assign unused_pc_bits = ^{if_pc[1:0], if_pc[31:TAG_HI+1]};

    // Lookup reads table state only; same-cycle updates become visible next cycle.
    assign pred_taken  = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && ctr_q[if_idx][1];
    assign pred_target = valid_q[if_idx] ? target_q[if_idx] : 32'd0;

    assign upd    = ex_valid && ex_branch;
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_comb begin
        ctr_nxt = ctr_q[ex_idx];
        if (!ex_hit)
            ctr_nxt = ex_taken ? 2'd2 : 2'd1;
        else if (ex_taken)
            ctr_nxt = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
        else
            ctr_nxt = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
    end

    // A non-branch predicted taken means a stale alias hit; it still needs a redirect.
    always_comb begin
        mis_d = 1'b0;
        if (ex_valid) begin
            if (ex_branch)
                mis_d = (ex_taken != ex_pred_taken) ||
                        (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
            else
                mis_d = ex_pred_taken;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'd1;
            end
        end else if (upd) begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            ctr_q[ex_idx]   <= ctr_nxt;
            if (ex_taken)
                target_q[ex_idx] <= ex_target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mispredict  <= 1'b0;
            redirect_pc <= 32'd0;
        end else begin
            mispredict <= mis_d;
            if (mis_d)
                redirect_pc <= (ex_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
        end
    end

`ifdef BP_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            if (upd)
                branch_count <= branch_count + 32'd1;
            if (mispredict)
                mispredict_count <= mispredict_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; expected values are hand-computed per scenario.
module tb_branch_predictor;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
    logic [31:0] branch_count, mispredict_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    branch_predictor #(.INDEX_BITS(6), .TAG_BITS(8)) dut (
        .clock(clock), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_pc(ex_pc),
        .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
        , .branch_count(branch_count), .mispredict_count(mispredict_count)
`endif
    );

    // Drive one EX-stage instruction at the negedge, then sample #1 after the next posedge.
    task automatic ex_cycle(input logic v, input logic br, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        @(negedge clock);
        ex_valid = v; ex_branch = br; ex_pc = pc; ex_taken = tk;
        ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        @(posedge clock);
        #1;
        ex_valid = 1'b0; ex_branch = 1'b0; ex_pred_taken = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        if_pc = pc;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        look(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'd0) begin errors++; $display("FAIL reset_pred_target got %h want 0", pred_target); end
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL reset_mispredict got %0b want 0", mispredict); end
        checks++; if (redirect_pc !== 32'd0) begin errors++; $display("FAIL reset_redirect got %h want 0", redirect_pc); end
    endtask

    task automatic test_allocate;
        ex_cycle(1, 1, 32'h100, 1, 32'h80, 0, 32'h0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL alloc_mispredict got %0b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL alloc_redirect got %h want 80", redirect_pc); end
        look(32'h100);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alloc_pred_taken got %0b want 1", pred_taken); end
        checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL alloc_pred_target got %h want 80", pred_target); end
    endtask

    task automatic test_training;
        // ctr 2 -> 3, saturates
        repeat (3) ex_cycle(1, 1, 32'h100, 1, 32'h80, 1, 32'h80);
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL train_correct_mispredict got %0b want 0", mispredict); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL train_redirect_hold got %h want 80", redirect_pc); end
        ex_cycle(1, 1, 32'h100, 0, 32'h0, 1, 32'h80);   // 3 -> 2, mispredict via outcome
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL train_nt_mispredict got %0b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL train_nt_redirect got %h want 104", redirect_pc); end
        look(32'h100);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_ctr2_pred got %0b want 1", pred_taken); end
        ex_cycle(1, 1, 32'h100, 0, 32'h0, 1, 32'h80);   // 2 -> 1
        look(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL train_ctr1_pred got %0b want 0", pred_taken); end
        repeat (4) ex_cycle(1, 1, 32'h100, 0, 32'h0, 0, 32'h0);  // saturates at 0
        ex_cycle(1, 1, 32'h100, 1, 32'h80, 0, 32'h0);   // 0 -> 1 (a wrap would give 3)
        look(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL train_no_wrap got %0b want 0", pred_taken); end
        ex_cycle(1, 1, 32'h100, 1, 32'h80, 0, 32'h0);   // 1 -> 2
        look(32'h100);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL train_ctr2_again got %0b want 1", pred_taken); end
        // right direction, wrong target
        ex_cycle(1, 1, 32'h100, 1, 32'h90, 1, 32'h80);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL target_mispredict got %0b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h90) begin errors++; $display("FAIL target_redirect got %h want 90", redirect_pc); end
        look(32'h100);
        checks++; if (pred_target !== 32'h90) begin errors++; $display("FAIL target_update got %h want 90", pred_target); end
    endtask

    task automatic test_alias;
        ex_cycle(1, 1, 32'h200, 1, 32'h300, 0, 32'h0);
        look(32'h100);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_old_pc got %0b want 0", pred_taken); end
        look(32'h200);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL alias_new_pred got %0b want 1", pred_taken); end
        checks++; if (pred_target !== 32'h300) begin errors++; $display("FAIL alias_new_target got %h want 300", pred_target); end
    endtask

    task automatic test_nonbranch;
        ex_cycle(1, 0, 32'h200, 0, 32'h0, 1, 32'h300);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL nonbr_mispredict got %0b want 1", mispredict); end
        checks++; if (redirect_pc !== 32'h204) begin errors++; $display("FAIL nonbr_redirect got %h want 204", redirect_pc); end
        look(32'h200);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL nonbr_table_pred got %0b want 1", pred_taken); end
        checks++; if (pred_target !== 32'h300) begin errors++; $display("FAIL nonbr_table_target got %h want 300", pred_target); end
        // bubble carrying mismatched prediction fields: nothing happens
        ex_cycle(0, 1, 32'h200, 0, 32'h0, 1, 32'h300);
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL bubble_mispredict got %0b want 0", mispredict); end
        checks++; if (redirect_pc !== 32'h204) begin errors++; $display("FAIL bubble_redirect got %h want 204", redirect_pc); end
        look(32'h200);
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL bubble_table got %0b want 1", pred_taken); end
    endtask

    task automatic test_same_cycle;
        @(negedge clock);
        if_pc = 32'h104;
        ex_valid = 1; ex_branch = 1; ex_pc = 32'h104; ex_taken = 1;
        ex_target = 32'h50; ex_pred_taken = 0; ex_pred_target = 32'h0;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL same_cycle_old_pred got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL same_cycle_old_target got %h want 0", pred_target); end
        @(posedge clock);
        #1;
        ex_valid = 0; ex_branch = 0;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL same_cycle_new_pred got %0b want 1", pred_taken); end
        checks++; if (pred_target !== 32'h50) begin errors++; $display("FAIL same_cycle_new_target got %h want 50", pred_target); end
    endtask

    task automatic test_reset_mid;
        @(negedge clock);
        reset = 1;
        ex_valid = 1; ex_branch = 1; ex_pc = 32'h108; ex_taken = 1;
        ex_target = 32'h60; ex_pred_taken = 0; ex_pred_target = 32'h0;
        @(posedge clock);
        #1;
        reset = 0; ex_valid = 0; ex_branch = 0;
        checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL rstmid_mispredict got %0b want 0", mispredict); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rstmid_redirect got %h want 0", redirect_pc); end
        look(32'h108);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rstmid_no_train got %0b want 0", pred_taken); end
        look(32'h104);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rstmid_cleared_pred got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL rstmid_cleared_target got %h want 0", pred_target); end
    endtask

`ifdef BP_STATS_EN
    task automatic test_stats;
        @(negedge clock); reset = 1;
        @(posedge clock); #1; reset = 0;
        checks++; if (branch_count !== 32'd0) begin errors++; $display("FAIL stats_reset_br got %0d want 0", branch_count); end
        ex_cycle(1, 1, 32'h10C, 1, 32'h40, 0, 32'h0);   // mispredict
        ex_cycle(1, 1, 32'h10C, 1, 32'h40, 1, 32'h40);
        ex_cycle(1, 1, 32'h10C, 0, 32'h0,  1, 32'h40);  // mispredict
        ex_cycle(1, 1, 32'h10C, 0, 32'h0,  0, 32'h0);
        ex_cycle(1, 1, 32'h10C, 0, 32'h0,  0, 32'h0);
        ex_cycle(0, 0, 32'h0,   0, 32'h0,  0, 32'h0);
        checks++; if (branch_count !== 32'd5) begin errors++; $display("FAIL stats_branch got %0d want 5", branch_count); end
        checks++; if (mispredict_count !== 32'd2) begin errors++; $display("FAIL stats_mispredict got %0d want 2", mispredict_count); end
    endtask
`endif

    initial begin
        reset = 1; if_pc = 0;
        ex_valid = 0; ex_branch = 0; ex_pc = 0; ex_taken = 0;
        ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
        test_reset();
        test_allocate();
        test_training();
        test_alias();
        test_nonbranch();
        test_same_cycle();
        test_reset_mid();
`ifdef BP_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
